// File: rtl/ias_fetch_unit_if.sv
// ias_fetch_unit_if: memory read bus between the fetch unit (master) and instruction memory (slave)
// Ports: mem_rd_req/mem_addr driven by master; mem_rd_ack/mem_rdata driven by slave
interface ias_fetch_unit_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 40
);
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_ack;
    logic [WORD_W-1:0] mem_rdata;
    modport master (output mem_rd_req, mem_addr, input mem_rd_ack, mem_rdata);
    modport slave  (input mem_rd_req, mem_addr, output mem_rd_ack, mem_rdata);
endinterface

// File: rtl/ias_fetch_unit.sv
// ias_fetch_unit: IAS instruction fetch stage with IBR buffering of the right-half instruction
// Ports: clk, reset (sync, active-low); fetch_req, load_pc, pc_target, jump_right from control unit;
//        bus (master) memory read handshake; instr_valid, opcode, operand_addr, pc, ibr_valid, busy status
module ias_fetch_unit #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 40,
    parameter int OPC_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic              jump_right,
    ias_fetch_unit_if.master  bus,
    output logic              instr_valid,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] operand_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              ibr_valid,
    output logic              busy
);
    localparam int INS_W = OPC_W + ADDR_W;
    typedef enum logic {IDLE, RD_WAIT} state_t;
    state_t           state;
    logic [INS_W-1:0] ibr;
    logic             right_only;
    logic             redirect;
    logic             fetch_pend;
    logic [INS_W-1:0] left_half;
    logic [INS_W-1:0] right_half;
    assign left_half  = bus.mem_rdata[WORD_W-1:INS_W];
    assign right_half = bus.mem_rdata[INS_W-1:0];
    assign busy       = state == RD_WAIT;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            bus.mem_rd_req <= 1'b0;
            bus.mem_addr   <= '0;
            instr_valid    <= 1'b0;
            opcode         <= '0;
            operand_addr   <= '0;
            pc             <= '0;
            ibr            <= '0;
            ibr_valid      <= 1'b0;
            right_only     <= 1'b0;
            redirect       <= 1'b0;
            fetch_pend     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_pc) begin
                        // a fetch arriving with the jump is remembered and issued next cycle
                        pc          <= pc_target;
                        ibr_valid   <= 1'b0;
                        instr_valid <= 1'b0;
                        right_only  <= jump_right;
                        fetch_pend  <= fetch_pend | fetch_req;
                    end else if (fetch_req || fetch_pend) begin
                        fetch_pend <= 1'b0;
                        if (ibr_valid) begin
                            {opcode, operand_addr} <= ibr;
                            instr_valid            <= 1'b1;
                            ibr_valid              <= 1'b0;
                            pc                     <= pc + 1'b1;
                        end else begin
                            bus.mem_rd_req <= 1'b1;
                            bus.mem_addr   <= pc;
                            instr_valid    <= 1'b0;
                            state          <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (load_pc) begin
                        pc         <= pc_target;
                        right_only <= jump_right;
                    end
                    if (bus.mem_rd_ack) begin
                        if (redirect || load_pc) begin
                            // stale data from before the jump: drop it and re-read at the new pc
                            bus.mem_addr <= load_pc ? pc_target : pc;
                            redirect     <= 1'b0;
                        end else begin
                            bus.mem_rd_req <= 1'b0;
                            instr_valid    <= 1'b1;
                            state          <= IDLE;
                            if (right_only) begin
                                {opcode, operand_addr} <= right_half;
                                ibr_valid              <= 1'b0;
                                pc                     <= pc + 1'b1;
                                right_only             <= 1'b0;
                            end else begin
                                {opcode, operand_addr} <= left_half;
                                ibr                    <= right_half;
                                ibr_valid              <= 1'b1;
                            end
                        end
                    end else if (load_pc) begin
                        redirect <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
